ro_pair_meas: RTL and testbench

RO_PAIR_MEAS -- requirements
Module: ro_pair_meas

---
 rtl/ro_pair_meas.sv | 129 ++++++++++++
 tb/tb_ro_pair_meas.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ro_pair_meas.sv
// Ring-oscillator pair sweep: for each pair, settle, count synchronized rising edges
// over a fixed window, and latch (cnt_a > cnt_b) into the response word.
module ro_pair_meas #(
  parameter int PAIRS    = 8,
  parameter int CNT_BITS = 16,
  parameter int WINDOW   = 1024,
  parameter int SETTLE   = 8
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_en,
  input  logic [PAIRS-1:0] I_ro_a,
  input  logic [PAIRS-1:0] I_ro_b,
  output logic [PAIRS-1:0] O_ro_sel,
  output logic [PAIRS-1:0] O_resp,
  output logic             O_meas_v,
  output logic             O_busy
);

  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAIRS - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TMR_W-1:0]      tmr_q;
  logic [CNT_BITS-1:0]   cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [2:0]            sync_a_q, sync_b_q;
  logic                  rise_a, rise_b;

  // Two synchronizer flops ([0],[1]) plus one history flop ([2]) for edge detection.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], I_ro_a[idx_q]};
      sync_b_q <= {sync_b_q[1:0], I_ro_b[idx_q]};
    end
  end

  assign rise_a = sync_a_q[1] & ~sync_a_q[2];
  assign rise_b = sync_b_q[1] & ~sync_b_q[2];

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (rise_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 1'b1;
    if (rise_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 1'b1;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst || !I_en) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      tmr_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      O_ro_sel <= '0;
      O_resp   <= '0;
      O_meas_v <= 1'b0;
      O_busy   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q  <= S_SETTLE;
          idx_q    <= '0;
          tmr_q    <= SETTLE_LD;
          cnt_a_q  <= '0;
          cnt_b_q  <= '0;
          O_ro_sel <= PAIRS'(1);
          O_busy   <= 1'b1;
        end
        S_SETTLE: begin
          cnt_a_q <= '0;
          cnt_b_q <= '0;
          if (tmr_q == '0) begin
            state_q <= S_COUNT;
            tmr_q   <= WINDOW_LD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_COUNT: begin
          // The final window cycle still accumulates; COMPARE sees the settled totals.
          cnt_a_q <= cnt_a_d;
          cnt_b_q <= cnt_b_d;
          if (tmr_q == '0) state_q <= S_COMPARE;
          else             tmr_q   <= tmr_q - 1'b1;
        end
        S_COMPARE: begin
          O_resp[idx_q] <= (cnt_a_q > cnt_b_q);
          if (idx_q == IDX_LAST) begin
            state_q  <= S_DONE;
            O_ro_sel <= '0;
            O_meas_v <= 1'b1;
            O_busy   <= 1'b0;
          end else begin
            state_q  <= S_SETTLE;
            idx_q    <= idx_q + 1'b1;
            tmr_q    <= SETTLE_LD;
            O_ro_sel <= O_ro_sel << 1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q  <= S_IDLE;
          O_ro_sel <= '0;
          O_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_pair_meas.sv
// Directed bench for ro_pair_meas: nominal, tie, saturation, mid-sweep reset and enable drop.
module tb_ro_pair_meas;

  localparam int P      = 4;
  localparam int W      = 64;
  localparam int S      = 4;
  localparam int PER    = S + W + 1;
  localparam int SWEEP  = P * PER;

  logic         clk = 1'b0;
  logic         rst, en, rst_s, en_s;
  logic [P-1:0] ro_a, ro_b, ro_a_s, ro_b_s;
  logic [P-1:0] sel, resp, sel_s, resp_s;
  logic         mv, busy, mv_s, busy_s;
  int           ph = 0;
  int           mode = 0;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  ro_pair_meas #(.PAIRS(P), .CNT_BITS(8), .WINDOW(W), .SETTLE(S)) dut (
    .I_clk(clk), .I_rst(rst), .I_en(en), .I_ro_a(ro_a), .I_ro_b(ro_b),
    .O_ro_sel(sel), .O_resp(resp), .O_meas_v(mv), .O_busy(busy)
  );

  ro_pair_meas #(.PAIRS(P), .CNT_BITS(4), .WINDOW(W), .SETTLE(S)) dut_s (
    .I_clk(clk), .I_rst(rst_s), .I_en(en_s), .I_ro_a(ro_a_s), .I_ro_b(ro_b_s),
    .O_ro_sel(sel_s), .O_resp(resp_s), .O_meas_v(mv_s), .O_busy(busy_s)
  );

  initial forever begin
    @(negedge clk);
    ph = ph + 1;
  end

  // mode 0: A every 4 clk, B every 8 clk; mode 1: A and B identical, every 4 clk
  always_comb begin
    ro_a = {P{((ph >> 2) & 1) == 1}};
    ro_b = (mode == 1) ? ro_a : {P{((ph >> 3) & 1) == 1}};
    ro_a_s = {P{((ph >> 1) & 1) == 1}};
    ro_b_s = {P{((ph / 3) % 2) == 1}};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the next posedge is cycle 0 of a fresh sweep.
  task automatic run_sweep(input logic [P-1:0] exp_resp, input string tag);
    int          rise_cyc;
    logic [P-1:0] esel, eresp;
    logic        ebusy, emv;
    rise_cyc = -1;
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < SWEEP + 10; k++) begin
      @(negedge clk);
      esel  = (k < SWEEP) ? P'(1 << (k / PER)) : '0;
      ebusy = (k < SWEEP);
      emv   = (k >= SWEEP);
      eresp = '0;
      for (int p = 0; p < P; p++)
        if (PER * p + PER <= k) eresp[p] = exp_resp[p];
      check({tag, "_outs"}, {21'd0, mv, busy, 1'b0, resp, 1'b0, sel},
            {21'd0, emv, ebusy, 1'b0, eresp, 1'b0, esel});
      if (mv && rise_cyc < 0) rise_cyc = k + 1;
    end
    check({tag, "_meas_v_cycle"}, rise_cyc, 277);
    check({tag, "_resp"}, resp, exp_resp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rst_s = 1'b1; en_s = 1'b1; mode = 0;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_resp", resp, 0);
    check("rst_meas_v", mv, 0);
    check("rst_busy", busy, 0);

    rst_s = 1'b0;
    run_sweep(4'b1111, "nominal");

    check("sat_meas_v", mv_s, 1);
    check("sat_resp", resp_s, 4'b1111);
    check("sat_cnt_a", dut_s.cnt_a_q, 15);

    en = 1'b0;
    @(negedge clk);
    check("en_off_outs", {mv, busy, resp, sel}, 0);
    mode = 1;
    run_sweep(4'b0000, "tie");

    en = 1'b0;
    @(negedge clk);
    mode = 0;
    en = 1'b1;
    repeat (150) @(negedge clk);
    check("mid_pre_sel", sel, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {mv, busy, resp, sel}, 0);
    run_sweep(4'b1111, "rst_restart");

    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (PER + PER) @(negedge clk);
    check("cmp1_pre_busy", busy, 1);
    check("cmp1_pre_resp", resp, 4'b0001);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_outs", {mv, busy, resp, sel}, 0);
    run_sweep(4'b1111, "en_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
